// File: rtl/dbg_probe_capture.sv
// dbg_probe_capture: routes one of N_CH probe buses to a registered observation
// port and records a triggered trace of DEPTH samples for serial readout.
// Channel select and trigger compare are loaded through a serial shift chain.
// Optional build macro DBG_PROBE_TRIG_MASK_EN adds a trigger mask field to the
// config chain (mask in the LSBs, reset to all-ones) and masks the compare.
// Handshake: inReadEnable is a pop request, honoured only in DONE with unread
// samples and no simultaneous inArm; each honoured pop yields a one-cycle
// outValid pulse on the following cycle with outData holding the sample.
module dbg_probe_capture #(
  parameter int N_CH  = 4,
  parameter int W     = 4,
  parameter int DEPTH = 16,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic                     inClock,
  input  logic                     inReset,
  input  logic [N_CH*W-1:0]        inProbe,
  input  logic                     inCfgShift,
  input  logic                     inCfgData,
  input  logic                     inCfgLoad,
  input  logic                     inArm,
  input  logic                     inReadEnable,
  output logic [W-1:0]             outObs,
  output logic [1:0]               outState,
  output logic                     outDone,
  output logic                     outEmpty,
  output logic [$clog2(DEPTH):0]   outCount,
  output logic [W-1:0]             outData,
  output logic                     outValid
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
`ifdef DBG_PROBE_TRIG_MASK_EN
  localparam int CW = SELW + 2 * W;
`else
  localparam int CW = SELW + W;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_sr;
  logic [SELW-1:0]   r_sel;
  logic [W-1:0]      r_cmp;
`ifdef DBG_PROBE_TRIG_MASK_EN
  logic [W-1:0]      r_mask;
`endif
  logic [W-1:0]      r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CNTW-1:0]   r_count;
  logic [W-1:0]      r_obs;
  logic [W-1:0]      r_data;
  logic              r_valid;

  logic [W-1:0]      w_m;
  logic              w_trig;
  logic              w_pop;
  logic              w_last_wr;

  // Shadow shift chain and active config; load takes the pre-shift shadow value.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      r_sr  <= '0;
      r_sel <= '0;
      r_cmp <= '0;
`ifdef DBG_PROBE_TRIG_MASK_EN
      r_mask <= '1;
`endif
    end else begin
      if (inCfgShift) r_sr <= {r_sr[CW-2:0], inCfgData};
      if (inCfgLoad) begin
`ifdef DBG_PROBE_TRIG_MASK_EN
        {r_sel, r_cmp, r_mask} <= r_sr;
`else
        {r_sel, r_cmp} <= r_sr;
`endif
      end
    end
  end

  // Channel mux; an out-of-range select observes zero.
  always_comb begin
    w_m = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_sel == SELW'(k)) w_m = inProbe[k*W +: W];
    end
  end

`ifdef DBG_PROBE_TRIG_MASK_EN
  assign w_trig = ((w_m & r_mask) == (r_cmp & r_mask));
`else
  assign w_trig = (w_m == r_cmp);
`endif

  // inArm in DONE pre-empts a pop issued in the same cycle.
  assign w_pop     = (r_state == S_DONE) && inReadEnable && !inArm && (r_count != '0);
  assign w_last_wr = (r_state == S_CAPTURE) && (r_wptr == AW'(DEPTH - 1));

  // FSM state register.
  always_ff @(posedge inClock) begin
    if (inReset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // FSM next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (inArm) w_next = S_ARMED;
      S_ARMED:   if (w_trig) w_next = S_CAPTURE;
      S_CAPTURE: if (w_last_wr) w_next = S_DONE;
      S_DONE: begin
        if (inArm)                            w_next = S_ARMED;
        else if (w_pop && r_count == CNTW'(1)) w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Observation register, trace write/read pointers, sample count and readout.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_obs   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_obs   <= w_m;
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (inArm) r_count <= '0;
        S_ARMED: begin
          if (w_trig) begin
            r_mem[0] <= w_m;
            r_wptr   <= AW'(1);
          end
        end
        S_CAPTURE: begin
          r_mem[r_wptr] <= w_m;
          r_wptr        <= r_wptr + AW'(1);
          if (w_last_wr) begin
            r_count <= CNTW'(DEPTH);
            r_rptr  <= '0;
          end
        end
        S_DONE: begin
          if (inArm) begin
            r_count <= '0;
          end else if (w_pop) begin
            r_data  <= r_mem[r_rptr];
            r_valid <= 1'b1;
            r_rptr  <= r_rptr + AW'(1);
            r_count <= r_count - CNTW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign outObs   = r_obs;
  assign outState = r_state;
  assign outDone  = (r_state == S_DONE);
  assign outEmpty = (r_count == '0);
  assign outCount = r_count;
  assign outData  = r_data;
  assign outValid = r_valid;

endmodule

// File: tb/tb_dbg_probe_capture.sv
// Directed bench for dbg_probe_capture (N_CH=4, W=4, DEPTH=16).
// Compile with +define+DBG_PROBE_TRIG_MASK_EN to exercise the masked trigger.
module tb_dbg_probe_capture;

  localparam int N_CH  = 4;
  localparam int W     = 4;
  localparam int DEPTH = 16;
  localparam int SELW  = 2;
`ifdef DBG_PROBE_TRIG_MASK_EN
  localparam int CW = SELW + 2 * W;
`else
  localparam int CW = SELW + W;
`endif

  logic              inClock;
  logic              inReset;
  logic [N_CH*W-1:0] inProbe;
  logic              inCfgShift;
  logic              inCfgData;
  logic              inCfgLoad;
  logic              inArm;
  logic              inReadEnable;
  logic [W-1:0]      outObs;
  logic [1:0]        outState;
  logic              outDone;
  logic              outEmpty;
  logic [4:0]        outCount;
  logic [W-1:0]      outData;
  logic              outValid;

  logic [W-1:0]      ch [N_CH];
  logic [W-1:0]      exp_q [$];
  int                tests;
  int                fails;

  dbg_probe_capture #(.N_CH(N_CH), .W(W), .DEPTH(DEPTH)) dut (
    .inClock(inClock), .inReset(inReset), .inProbe(inProbe),
    .inCfgShift(inCfgShift), .inCfgData(inCfgData), .inCfgLoad(inCfgLoad),
    .inArm(inArm), .inReadEnable(inReadEnable),
    .outObs(outObs), .outState(outState), .outDone(outDone),
    .outEmpty(outEmpty), .outCount(outCount), .outData(outData),
    .outValid(outValid)
  );

  for (genvar g = 0; g < N_CH; g++) begin : g_probe
    assign inProbe[g*W +: W] = ch[g];
  end

  // Clock and watchdog.
  initial inClock = 1'b0;
  always #5 inClock = ~inClock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drivers.
  task automatic step();
    @(posedge inClock);
    #1;
  endtask

  task automatic load_cfg(input logic [SELW-1:0] sel, input logic [W-1:0] cmp,
                          input logic [W-1:0] mask, input logic shift_on_load);
    logic [SELW+2*W-1:0] full;
    logic [CW-1:0]       word;
    full = {sel, cmp, mask};
`ifdef DBG_PROBE_TRIG_MASK_EN
    word = full;
`else
    word = full[SELW+2*W-1:W];
`endif
    for (int b = CW - 1; b >= 0; b--) begin
      inCfgShift = 1'b1;
      inCfgData  = word[b];
      step();
    end
    inCfgShift = shift_on_load;
    inCfgData  = 1'b1;
    inCfgLoad  = 1'b1;
    step();
    inCfgShift = 1'b0;
    inCfgData  = 1'b0;
    inCfgLoad  = 1'b0;
  endtask

  task automatic arm_and_ramp();
    logic done;
    done  = 1'b0;
    inArm = 1'b1;
    ch[2] = '0;
    step();
    inArm = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      ch[2] = W'(i);
      step();
      if (outState == 2'd3) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL capture_timeout: state %0d, required 3 within 64 cycles", outState);
    end
  endtask

  // Scenarios.
  task automatic test_reset();
    inReset = 1'b1;
    step();
    step();
    inReset = 1'b0;
    tests++;
    if ({outState, outObs, outCount, outDone, outValid, outData} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: state=%0d obs=%0h count=%0d done=%0b valid=%0b data=%0h, required all 0",
               outState, outObs, outCount, outDone, outValid, outData);
    end
    tests++;
    if (outEmpty !== 1'b1) begin
      fails++;
      $display("FAIL reset_empty: got %0b required 1", outEmpty);
    end
  endtask

  task automatic test_config_obs();
    ch[0] = 4'h1; ch[1] = 4'h3; ch[2] = 4'h5; ch[3] = 4'hC;
    // Shift during load: the active config must take the pre-shift shadow (sel=2).
    load_cfg(2'd2, 4'hA, 4'hF, 1'b1);
    step();
    tests++;
    if (outObs !== 4'h5) begin
      fails++;
      $display("FAIL obs_sel2_shift_on_load: got %0h required 5", outObs);
    end
    load_cfg(2'd1, 4'hA, 4'hF, 1'b0);
    step();
    tests++;
    if (outObs !== 4'h3) begin
      fails++;
      $display("FAIL obs_sel1: got %0h required 3", outObs);
    end
    load_cfg(2'd2, 4'hA, 4'hF, 1'b0);
    tests++;
    if (outObs !== 4'h3) begin
      fails++;
      $display("FAIL obs_latency: got %0h required 3 on the load edge", outObs);
    end
    step();
    tests++;
    if (outObs !== 4'h5) begin
      fails++;
      $display("FAIL obs_sel2: got %0h required 5", outObs);
    end
    tests++;
    if (outState !== 2'd0) begin
      fails++;
      $display("FAIL cfg_state_idle: got %0d required 0", outState);
    end
  endtask

  task automatic test_trigger_capture();
    logic [1:0] es;
    inArm = 1'b1;
    step();
    inArm = 1'b0;
    tests++;
    if (outState !== 2'd1) begin
      fails++;
      $display("FAIL arm_state: got %0d required 1", outState);
    end
    for (int i = 0; i < 26; i++) begin
      ch[2] = W'(i);
      inArm = (i == 3 || i == 15);
      step();
      es = (i < 10) ? 2'd1 : (i < 25) ? 2'd2 : 2'd3;
      tests++;
      if (outState !== es) begin
        fails++;
        $display("FAIL capture_state[%0d]: got %0d required %0d", i, outState, es);
      end
      if (i < 25) begin
        tests++;
        if (outCount !== 5'd0) begin
          fails++;
          $display("FAIL capture_count[%0d]: got %0d required 0", i, outCount);
        end
      end
    end
    inArm = 1'b0;
    tests++;
    if (outCount !== 5'd16 || outDone !== 1'b1 || outEmpty !== 1'b0) begin
      fails++;
      $display("FAIL done_status: count=%0d done=%0b empty=%0b, required 16/1/0",
               outCount, outDone, outEmpty);
    end
  endtask

  task automatic test_readout();
    int pulses;
    logic [W-1:0] expv;
    pulses = 0;
    exp_q.delete();
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(W'(10 + k));
    inReadEnable = 1'b1;
    for (int c = 0; c < 18; c++) begin
      step();
      if (outValid === 1'b1) begin
        pulses++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL read_extra[%0d]: outValid with data %0h, required no pulse", c, outData);
        end else begin
          expv = exp_q.pop_front();
          if (outData !== expv) begin
            fails++;
            $display("FAIL read_data[%0d]: got %0h required %0h", c, outData, expv);
          end
        end
      end
      if (c == 15) begin
        tests++;
        if (outState !== 2'd0 || outCount !== 5'd0 || outEmpty !== 1'b1) begin
          fails++;
          $display("FAIL read_last: state=%0d count=%0d empty=%0b, required 0/0/1",
                   outState, outCount, outEmpty);
        end
      end
    end
    inReadEnable = 1'b0;
    tests++;
    if (pulses !== 16) begin
      fails++;
      $display("FAIL read_pulses: got %0d required 16", pulses);
    end
    tests++;
    if (outData !== 4'h9) begin
      fails++;
      $display("FAIL read_hold: got %0h required 9", outData);
    end
  endtask

  task automatic test_rearm_in_done();
    arm_and_ramp();
    inReadEnable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if (outValid !== 1'b1 || outData !== W'(10 + c)) begin
        fails++;
        $display("FAIL rearm_read[%0d]: valid=%0b data=%0h, required 1/%0h",
                 c, outValid, outData, W'(10 + c));
      end
    end
    inArm = 1'b1;
    step();
    inArm = 1'b0;
    inReadEnable = 1'b0;
    tests++;
    if (outCount !== 5'd0 || outState !== 2'd1 || outValid !== 1'b0) begin
      fails++;
      $display("FAIL rearm: count=%0d state=%0d valid=%0b, required 0/1/0",
               outCount, outState, outValid);
    end
    tests++;
    if (outData !== 4'hE) begin
      fails++;
      $display("FAIL rearm_data_hold: got %0h required e", outData);
    end
  endtask

  task automatic test_reset_mid_capture();
    // Still ARMED from the previous scenario with sel=2, cmp=A.
    for (int i = 0; i < 17; i++) begin
      ch[2] = W'(i);
      step();
    end
    tests++;
    if (outState !== 2'd2) begin
      fails++;
      $display("FAIL pre_reset_state: got %0d required 2", outState);
    end
    ch[2]   = W'(17);
    inReset = 1'b1;
    step();
    inReset = 1'b0;
    tests++;
    if (outState !== 2'd0 || outObs !== 4'h0 || outCount !== 5'd0 || outEmpty !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset: state=%0d obs=%0h count=%0d empty=%0b, required 0/0/0/1",
               outState, outObs, outCount, outEmpty);
    end
    ch[0] = 4'h7;
    step();
    tests++;
    if (outObs !== 4'h7) begin
      fails++;
      $display("FAIL reset_sel0: got %0h required 7", outObs);
    end
    inReadEnable = 1'b1;
    step();
    inReadEnable = 1'b0;
    tests++;
    if (outValid !== 1'b0) begin
      fails++;
      $display("FAIL read_after_reset: valid %0b required 0", outValid);
    end
    // cmp cleared to 0: a value of 3 must not trigger, 0 must.
    ch[0] = 4'h3;
    inArm = 1'b1;
    step();
    inArm = 1'b0;
    step();
    tests++;
    if (outState !== 2'd1) begin
      fails++;
      $display("FAIL reset_cmp_hold: state %0d required 1", outState);
    end
    ch[0] = 4'h0;
    step();
    tests++;
    if (outState !== 2'd2) begin
      fails++;
      $display("FAIL reset_cmp_zero: state %0d required 2", outState);
    end
    inReset = 1'b1;
    step();
    inReset = 1'b0;
  endtask

  task automatic test_mask();
`ifdef DBG_PROBE_TRIG_MASK_EN
    load_cfg(2'd2, 4'h8, 4'h8, 1'b0);
    inArm = 1'b1;
    ch[2] = '0;
    step();
    inArm = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ch[2] = W'(i);
      step();
      tests++;
      if (outState !== ((i < 8) ? 2'd1 : 2'd2)) begin
        fails++;
        $display("FAIL mask_trig[%0d]: state %0d required %0d", i, outState, (i < 8) ? 1 : 2);
      end
    end
    for (int i = 9; i < 24; i++) begin
      ch[2] = W'(i);
      step();
    end
    tests++;
    if (outState !== 2'd3) begin
      fails++;
      $display("FAIL mask_done: state %0d required 3", outState);
    end
    inReadEnable = 1'b1;
    step();
    inReadEnable = 1'b0;
    tests++;
    if (outValid !== 1'b1 || outData !== 4'h8) begin
      fails++;
      $display("FAIL mask_first_sample: valid=%0b data=%0h, required 1/8", outValid, outData);
    end
`else
    load_cfg(2'd2, 4'h8, 4'hF, 1'b0);
    inArm = 1'b1;
    ch[2] = 4'h9;
    step();
    inArm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (outState !== 2'd1) begin
        fails++;
        $display("FAIL exact_no_trig[%0d]: state %0d required 1", i, outState);
      end
    end
    ch[2] = 4'h8;
    step();
    tests++;
    if (outState !== 2'd2) begin
      fails++;
      $display("FAIL exact_trig: state %0d required 2", outState);
    end
`endif
    inReset = 1'b1;
    step();
    inReset = 1'b0;
  endtask

  // Main sequence and report.
  initial begin
    tests = 0;
    fails = 0;
    inReset = 1'b1; inCfgShift = 1'b0; inCfgData = 1'b0; inCfgLoad = 1'b0;
    inArm = 1'b0; inReadEnable = 1'b0;
    for (int k = 0; k < N_CH; k++) ch[k] = '0;
    test_reset();
    test_config_obs();
    test_trigger_capture();
    test_readout();
    test_rearm_in_done();
    test_reset_mid_capture();
    test_mask();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
